atomrvcore_ifu: RTL and testbench

Instruction fetch unit. It is the producer end of the fetch→decode interface and feeds instr/PC into the decode stage. It consumes the decode stage's control-flow outputs (SB_EN, UJE, JALRE, immed) to redirect the PC. It talks to instruction memory over a single-outstanding req/gnt/rvalid handshake, and holds its output under decode back-pressure.

---
 rtl/atomrvcore_ifu.sv | 192 +++++++++++++++++++
 tb/tb_atomrvcore_ifu.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/atomrvcore_ifu.sv
// Instruction fetch unit: single-outstanding req/gnt/rvalid imem master feeding a
// one-entry instruction slot to decode, with PC redirect on branch/jump/PC reset.
module atomrvcore_ifu #(
  parameter int unsigned          DATAWIDTH = 32,
  parameter logic [DATAWIDTH-1:0] BOOT_ADDR = 32'h0000_0000,
  parameter logic [DATAWIDTH-1:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 PCrst_i,
  input  logic                 IR_EN_i,
  output logic                 imem_req_o,
  output logic [DATAWIDTH-1:0] imem_addr_o,
  input  logic                 imem_gnt_i,
  input  logic                 imem_rvalid_i,
  input  logic [DATAWIDTH-1:0] imem_rdata_i,
  output logic [DATAWIDTH-1:0] instr_o,
  output logic [DATAWIDTH-1:0] PC_o,
  output logic                 instr_valid_o,
  input  logic                 id_ready_i,
  input  logic                 SB_EN_i,
  input  logic                 branch_taken_i,
  input  logic                 UJE_i,
  input  logic                 JALRE_i,
  input  logic [DATAWIDTH-1:0] immed_i,
  input  logic [DATAWIDTH-1:0] operand_A_i,
  input  logic [DATAWIDTH-1:0] redir_pc_i,
  output logic                 fetch_misalign_o
);

  localparam logic [DATAWIDTH-1:0] PC_STEP   = DATAWIDTH'(4);
  localparam logic [DATAWIDTH-1:0] HALF_MASK = ~DATAWIDTH'(1);
  localparam logic [DATAWIDTH-1:0] WORD_MASK = ~DATAWIDTH'(3);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    WAIT  = 2'd2,
    FLUSH = 2'd3
  } state_t;

  state_t               state;
  logic [DATAWIDTH-1:0] pc_q;
  logic                 flush_pend;
  logic                 rsp_have;
  logic [DATAWIDTH-1:0] rsp_data;

  logic                 redirect;
  logic [DATAWIDTH-1:0] target_raw;
  logic [DATAWIDTH-1:0] target;
  logic                 consume;
  logic                 slot_ok;
  logic                 issue_ok;
  logic                 rsp_avail;
  logic [DATAWIDTH-1:0] rsp_word;

  always_comb begin
    redirect   = JALRE_i | UJE_i | (SB_EN_i & branch_taken_i) | ~PCrst_i;
    target_raw = BOOT_ADDR;
    if (!PCrst_i) begin
      target_raw = BOOT_ADDR;
    end else if (JALRE_i) begin
      target_raw = (operand_A_i + immed_i) & HALF_MASK;
    end else begin
      target_raw = redir_pc_i + (immed_i << 1);
    end
    target = target_raw & WORD_MASK;
  end

  // The slot can take a new word when empty or when decode is draining it now.
  always_comb begin
    consume   = instr_valid_o & id_ready_i;
    slot_ok   = ~instr_valid_o | id_ready_i;
    issue_ok  = IR_EN_i & slot_ok;
    rsp_avail = imem_rvalid_i | rsp_have;
    rsp_word  = rsp_have ? rsp_data : imem_rdata_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state            <= IDLE;
      pc_q             <= BOOT_ADDR;
      flush_pend       <= 1'b0;
      rsp_have         <= 1'b0;
      rsp_data         <= '0;
      imem_req_o       <= 1'b0;
      imem_addr_o      <= BOOT_ADDR;
      instr_o          <= NOP_INSTR;
      PC_o             <= '0;
      instr_valid_o    <= 1'b0;
      fetch_misalign_o <= 1'b0;
    end else begin
      fetch_misalign_o <= redirect & target_raw[1];

      if (redirect || consume) begin
        instr_valid_o <= 1'b0;
        instr_o       <= NOP_INSTR;
      end

      case (state)
        IDLE: begin
          if (redirect) begin
            pc_q <= target;
            if (IR_EN_i) begin
              state       <= REQ;
              imem_req_o  <= 1'b1;
              imem_addr_o <= target;
            end
          end else if (issue_ok) begin
            state       <= REQ;
            imem_req_o  <= 1'b1;
            imem_addr_o <= pc_q;
          end
        end

        // The request is never retracted; a redirect here only marks the
        // eventual response as stale.
        REQ: begin
          if (redirect) begin
            pc_q <= target;
          end
          if (imem_gnt_i) begin
            imem_req_o <= 1'b0;
            if (redirect || flush_pend) begin
              state      <= FLUSH;
              flush_pend <= 1'b0;
            end else begin
              pc_q  <= pc_q + PC_STEP;
              state <= WAIT;
            end
          end else if (redirect) begin
            flush_pend <= 1'b1;
          end
        end

        WAIT: begin
          if (redirect) begin
            pc_q     <= target;
            rsp_have <= 1'b0;
            if (rsp_avail) begin
              if (IR_EN_i) begin
                state       <= REQ;
                imem_req_o  <= 1'b1;
                imem_addr_o <= target;
              end else begin
                state <= IDLE;
              end
            end else begin
              state <= FLUSH;
            end
          end else if (rsp_avail) begin
            if (slot_ok) begin
              instr_o       <= rsp_word;
              PC_o          <= imem_addr_o;
              instr_valid_o <= 1'b1;
              rsp_have      <= 1'b0;
              if (issue_ok) begin
                state       <= REQ;
                imem_req_o  <= 1'b1;
                imem_addr_o <= pc_q;
              end else begin
                state <= IDLE;
              end
            end else if (!rsp_have) begin
              // Decode is stalled: park the returned word until the slot frees.
              rsp_have <= 1'b1;
              rsp_data <= imem_rdata_i;
            end
          end
        end

        FLUSH: begin
          if (redirect) begin
            pc_q <= target;
          end
          if (imem_rvalid_i) begin
            if (IR_EN_i) begin
              state       <= REQ;
              imem_req_o  <= 1'b1;
              imem_addr_o <= redirect ? target : pc_q;
            end else begin
              state <= IDLE;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_atomrvcore_ifu.sv
// Bench for atomrvcore_ifu: directed scenarios plus a random phase, checked
// against a PC-stream scoreboard and a protocol-level memory model.
module tb_atomrvcore_ifu;

  localparam logic [31:0] BOOT = 32'h0000_0000;
  localparam logic [31:0] NOP  = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b1;
  logic        PCrst_i = 1'b1;
  logic        IR_EN_i = 1'b0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i = 1'b0;
  logic        imem_rvalid_i = 1'b0;
  logic [31:0] imem_rdata_i = '0;
  logic [31:0] instr_o;
  logic [31:0] PC_o;
  logic        instr_valid_o;
  logic        id_ready_i = 1'b1;
  logic        SB_EN_i = 1'b0;
  logic        branch_taken_i = 1'b0;
  logic        UJE_i = 1'b0;
  logic        JALRE_i = 1'b0;
  logic [31:0] immed_i = '0;
  logic [31:0] operand_A_i = '0;
  logic [31:0] redir_pc_i = '0;
  logic        fetch_misalign_o;

  always #5 clk = ~clk;

  atomrvcore_ifu #(
    .DATAWIDTH(32),
    .BOOT_ADDR(BOOT),
    .NOP_INSTR(NOP)
  ) dut (
    .clk_i           (clk),
    .rst_ni          (rst_ni),
    .PCrst_i         (PCrst_i),
    .IR_EN_i         (IR_EN_i),
    .imem_req_o      (imem_req_o),
    .imem_addr_o     (imem_addr_o),
    .imem_gnt_i      (imem_gnt_i),
    .imem_rvalid_i   (imem_rvalid_i),
    .imem_rdata_i    (imem_rdata_i),
    .instr_o         (instr_o),
    .PC_o            (PC_o),
    .instr_valid_o   (instr_valid_o),
    .id_ready_i      (id_ready_i),
    .SB_EN_i         (SB_EN_i),
    .branch_taken_i  (branch_taken_i),
    .UJE_i           (UJE_i),
    .JALRE_i         (JALRE_i),
    .immed_i         (immed_i),
    .operand_A_i     (operand_A_i),
    .redir_pc_i      (redir_pc_i),
    .fetch_misalign_o(fetch_misalign_o)
  );

  int checks = 0;
  int failures = 0;

  // Scoreboard: next PC decode must see, and the expected misalign pulse.
  logic [31:0] exp_pc = BOOT;
  logic        exp_mis = 1'b0;
  int          deliveries = 0;

  // Memory model state.
  logic        mem_pend = 1'b0;
  logic [31:0] mem_addr = '0;
  int          mem_due = 0;
  int          gnt_cnt = 0;
  int          gnt_delay = 0;
  int          rsp_extra = 0;
  bit          rand_mem = 1'b0;

  // Previous-cycle observations for protocol checks.
  logic        prev_req = 1'b0, prev_gnt = 1'b0, prev_en = 1'b0;
  logic        prev_valid = 1'b0, prev_ready = 1'b0, prev_redir = 1'b0;
  logic [31:0] prev_addr = '0, prev_instr = '0, prev_pc = '0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    check(tag, {31'b0, obs}, {31'b0, exp});
  endtask

  // One clock cycle: memory answers, scoreboard/protocol checks, then the edge.
  task automatic tick();
    logic        r;
    logic        new_req;
    logic [31:0] raw;
    imem_gnt_i    = imem_req_o && (gnt_cnt >= gnt_delay);
    imem_rvalid_i = mem_pend && (mem_due == 0);
    imem_rdata_i  = imem_rvalid_i ? mem_word(mem_addr) : 32'hDEAD_BEEF;

    chk1("single_outstanding", imem_req_o & mem_pend, 1'b0);
    chk1("misalign_pulse", fetch_misalign_o, exp_mis);
    if (!instr_valid_o) check("nop_when_invalid", instr_o, NOP);
    if (imem_req_o) check("addr_aligned", {30'b0, imem_addr_o[1:0]}, 32'd0);
    if (prev_req && !prev_gnt) begin
      chk1("req_held", imem_req_o, 1'b1);
      check("addr_held", imem_addr_o, prev_addr);
    end
    new_req = imem_req_o && !(prev_req && !prev_gnt);
    if (new_req) begin
      chk1("new_req_needs_en", prev_en, 1'b1);
      chk1("new_req_backpressure", !prev_valid || prev_ready || prev_redir, 1'b1);
    end
    if (prev_redir) begin
      chk1("invalid_after_redirect", instr_valid_o, 1'b0);
    end else if (prev_valid && !prev_ready) begin
      chk1("hold_valid", instr_valid_o, 1'b1);
      check("hold_instr", instr_o, prev_instr);
      check("hold_pc", PC_o, prev_pc);
    end
    if (instr_valid_o && id_ready_i) begin
      check("deliver_pc", PC_o, exp_pc);
      check("deliver_instr", instr_o, mem_word(exp_pc));
      exp_pc = exp_pc + 32'd4;
      deliveries++;
    end

    r = UJE_i | JALRE_i | (SB_EN_i & branch_taken_i) | !PCrst_i;
    if (!PCrst_i)     raw = BOOT;
    else if (JALRE_i) raw = (operand_A_i + immed_i) & 32'hFFFF_FFFE;
    else              raw = redir_pc_i + immed_i * 32'd2;
    if (r) exp_pc = raw & 32'hFFFF_FFFC;
    exp_mis = r && raw[1];

    prev_req   = imem_req_o;    prev_gnt   = imem_gnt_i;  prev_addr = imem_addr_o;
    prev_valid = instr_valid_o; prev_ready = id_ready_i;  prev_redir = r;
    prev_instr = instr_o;       prev_pc    = PC_o;        prev_en = IR_EN_i;

    if (imem_rvalid_i) mem_pend = 1'b0;
    else if (mem_pend && mem_due > 0) mem_due--;
    if (imem_gnt_i) begin
      mem_pend = 1'b1;
      mem_addr = imem_addr_o;
      mem_due  = rand_mem ? int'($urandom_range(0, 2)) : rsp_extra;
      if (rand_mem) gnt_delay = int'($urandom_range(0, 3));
    end
    if (imem_req_o && !imem_gnt_i) gnt_cnt++;
    else gnt_cnt = 0;

    @(posedge clk);
    #1;
    UJE_i = 1'b0; JALRE_i = 1'b0; SB_EN_i = 1'b0; branch_taken_i = 1'b0;
    imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0;
  endtask

  task automatic apply_reset(input string tag);
    rst_ni = 1'b0;
    #1;
    chk1({tag, "_req"}, imem_req_o, 1'b0);
    check({tag, "_addr"}, imem_addr_o, BOOT);
    check({tag, "_instr"}, instr_o, NOP);
    check({tag, "_pc"}, PC_o, 32'd0);
    chk1({tag, "_valid"}, instr_valid_o, 1'b0);
    chk1({tag, "_misalign"}, fetch_misalign_o, 1'b0);
    mem_pend = 1'b0; gnt_cnt = 0;
    imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_ni = 1'b1;
    exp_pc = BOOT; exp_mis = 1'b0;
    prev_req = 1'b0; prev_gnt = 1'b0; prev_en = 1'b0;
    prev_valid = 1'b0; prev_ready = 1'b0; prev_redir = 1'b0;
  endtask

  task automatic wait_valid(input string tag, input int bound);
    for (int k = 0; k < bound && !instr_valid_o; k++) tick();
    chk1(tag, instr_valid_o, 1'b1);
  endtask

  task automatic drain();
    IR_EN_i = 1'b0;
    id_ready_i = 1'b1;
    for (int k = 0; k < 30 && (imem_req_o || mem_pend); k++) tick();
    chk1("drain_idle", imem_req_o || mem_pend, 1'b0);
    tick();
    tick();
  endtask

  initial begin
    int          first_valid;
    int          d0;
    logic [31:0] held_pc;

    #2;
    apply_reset("reset");

    // Sequential fetch from boot, zero-wait memory.
    IR_EN_i = 1'b1; id_ready_i = 1'b1;
    first_valid = 0;
    for (int k = 1; k <= 10 && first_valid == 0; k++) begin
      tick();
      if (k == 1) begin
        chk1("first_req", imem_req_o, 1'b1);
        check("first_addr", imem_addr_o, BOOT);
      end
      if (instr_valid_o) first_valid = k;
    end
    check("first_valid_latency", first_valid, 32'd3);
    repeat (8) tick();
    chk1("seq_progress", deliveries >= 3, 1'b1);

    // Decode back-pressure for 5 cycles, then resume without a bubble.
    id_ready_i = 1'b0;
    wait_valid("bp_valid_seen", 20);
    held_pc = PC_o;
    repeat (5) tick();
    check("bp_held_pc", PC_o, held_pc);
    id_ready_i = 1'b1;
    tick();
    chk1("bp_no_bubble", instr_valid_o, 1'b1);
    check("bp_next_pc", PC_o, held_pc + 32'd4);

    // JAL while a response is outstanding.
    rsp_extra = 2;
    for (int k = 0; k < 20 && !mem_pend; k++) tick();
    chk1("jal_outstanding", mem_pend, 1'b1);
    UJE_i = 1'b1; redir_pc_i = 32'h100; immed_i = 32'h20;
    tick();
    rsp_extra = 0;
    for (int k = 0; k < 20 && !imem_req_o; k++) tick();
    check("jal_req_addr", imem_addr_o, 32'h140);
    wait_valid("jal_valid", 20);
    check("jal_pc", PC_o, 32'h140);

    // JALR from an idle fetch: best-case latency and misalign pulse.
    drain();
    IR_EN_i = 1'b1;
    JALRE_i = 1'b1; operand_A_i = 32'h203; immed_i = 32'h4;
    tick();
    chk1("jalr_req", imem_req_o, 1'b1);
    check("jalr_addr", imem_addr_o, 32'h204);
    chk1("jalr_misalign", fetch_misalign_o, 1'b1);
    tick();
    chk1("jalr_misalign_once", fetch_misalign_o, 1'b0);
    tick();
    chk1("jalr_valid_t3", instr_valid_o, 1'b1);
    check("jalr_pc", PC_o, 32'h204);

    // Branch not taken: no redirect, stream continues sequentially.
    SB_EN_i = 1'b1; branch_taken_i = 1'b0; redir_pc_i = 32'h800; immed_i = 32'h40;
    tick();
    d0 = deliveries;
    repeat (8) tick();
    chk1("branch_nt_progress", deliveries > d0, 1'b1);

    // Slow grant with a redirect during the held request.
    drain();
    gnt_delay = 4;
    IR_EN_i = 1'b1;
    tick();
    chk1("slow_req_up", imem_req_o, 1'b1);
    tick();
    UJE_i = 1'b1; redir_pc_i = 32'h300; immed_i = 32'h10;
    tick();
    chk1("slow_req_kept", imem_req_o, 1'b1);
    for (int k = 0; k < 40 && !(imem_req_o && imem_addr_o == 32'h320); k++) tick();
    check("slow_target_addr", imem_addr_o, 32'h320);
    wait_valid("slow_valid", 40);
    check("slow_pc", PC_o, 32'h320);
    gnt_delay = 0;

    // Reset in WAIT, reset under back-pressure, then PC reset from decode.
    rsp_extra = 2;
    for (int k = 0; k < 20 && !mem_pend; k++) tick();
    chk1("rst_wait_outstanding", mem_pend, 1'b1);
    apply_reset("rst_wait");
    rsp_extra = 0;
    IR_EN_i = 1'b1; id_ready_i = 1'b0;
    wait_valid("rst_bp_valid", 30);
    apply_reset("rst_bp");
    id_ready_i = 1'b1;
    repeat (6) tick();
    PCrst_i = 1'b0;
    repeat (3) begin
      tick();
      chk1("pcrst_invalid", instr_valid_o, 1'b0);
    end
    PCrst_i = 1'b1;
    wait_valid("pcrst_restart_valid", 30);
    check("pcrst_restart_pc", PC_o, BOOT);

    // Random traffic: memory timing, back-pressure, enables and redirects.
    rand_mem = 1'b1;
    d0 = deliveries;
    for (int c = 0; c < 2000; c++) begin
      id_ready_i = ($urandom_range(0, 3) != 0);
      IR_EN_i    = ($urandom_range(0, 9) != 0);
      PCrst_i    = ($urandom_range(0, 99) != 0);
      if ($urandom_range(0, 19) == 0) begin
        UJE_i          = 1'($urandom_range(0, 1));
        JALRE_i        = 1'($urandom_range(0, 1));
        SB_EN_i        = 1'($urandom_range(0, 1));
        branch_taken_i = 1'($urandom_range(0, 1));
        redir_pc_i     = $urandom;
        immed_i        = $urandom;
        operand_A_i    = $urandom;
      end
      tick();
    end
    PCrst_i = 1'b1;
    chk1("random_progress", deliveries > d0 + 100, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
